// File: rtl/demux_1to8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : demux_1to8                                                       |
// | Brief   : 1-to-2**SEL_W demultiplexer, optional async-reset output reg.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module demux_1to8 #(
  parameter int SEL_W   = 3,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   out
);

  localparam int C_OUT_W = 2**SEL_W;

  logic [C_OUT_W-1:0] w_next_out;

  // Per-bit equality decode keeps the result one-hot for every known sel.
  for (genvar k = 0; k < C_OUT_W; k++) begin : g_decode
    assign w_next_out[k] = in & (sel == SEL_W'(k));
  end

  if (REG_OUT) begin : g_reg_out
    logic [C_OUT_W-1:0] r_out;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out <= '0;
      end else begin
        r_out <= w_next_out;
      end
    end

    assign out = r_out;
  end else begin : g_comb_out
    // clk and rst have no function in the combinational build.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    assign out = w_next_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_1to8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_demux_1to8                                                    |
// | Brief   : Directed and random checks of registered and combinational demux.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_demux_1to8;

  logic       clk;
  logic       rst;
  logic       in;
  logic [2:0] sel;
  logic [7:0] out_reg;
  logic [7:0] out_comb;

  int n_checks;
  int n_errors;

  demux_1to8 #(.SEL_W(3), .REG_OUT(1'b1)) u_dut_reg (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .sel (sel),
    .out (out_reg)
  );

  demux_1to8 #(.SEL_W(3), .REG_OUT(1'b0)) u_dut_comb (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .sel (sel),
    .out (out_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, check combinational output at once and
  // registered output just after the following rising edge.
  task automatic apply(input logic i_v, input logic [2:0] s_v, input logic [7:0] exp, input string tag);
    @(negedge clk);
    in  = i_v;
    sel = s_v;
    #1;
    check({tag, "_comb"}, out_comb, exp);
    @(posedge clk);
    #1;
    check({tag, "_reg"}, out_reg, exp);
  endtask

  logic [7:0] onehot_tbl [8];
  logic [7:0] exp_v;
  logic       ri;
  logic [2:0] rs;

  initial begin
    onehot_tbl[0] = 8'h01; onehot_tbl[1] = 8'h02;
    onehot_tbl[2] = 8'h04; onehot_tbl[3] = 8'h08;
    onehot_tbl[4] = 8'h10; onehot_tbl[5] = 8'h20;
    onehot_tbl[6] = 8'h40; onehot_tbl[7] = 8'h80;
    n_checks = 0;
    n_errors = 0;

    // Reset asserted with live stimulus: registered output cleared, comb ignores rst.
    rst = 1'b1;
    in  = 1'b1;
    sel = 3'd5;
    #1;
    check("rst_async_reg", out_reg, 8'h00);
    check("rst_comb", out_comb, 8'h20);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_reg", out_reg, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_noedge", out_reg, 8'h00);
    @(posedge clk);
    #1;
    check("first_capture", out_reg, 8'h20);

    // in=0 sweep
    for (int s = 0; s < 8; s++) apply(1'b0, 3'(s), 8'h00, "in0_sweep");

    // in=1 sweep
    for (int s = 0; s < 8; s++) apply(1'b1, 3'(s), onehot_tbl[s], "in1_sweep");

    // Toggle in with sel=3
    apply(1'b1, 3'd3, 8'h08, "tog_a");
    apply(1'b0, 3'd3, 8'h00, "tog_b");
    apply(1'b1, 3'd3, 8'h08, "tog_c");

    // Mid-operation reset between edges
    apply(1'b1, 3'd7, 8'h80, "mid_pre");
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_async", out_reg, 8'h00);
    check("mid_rst_comb", out_comb, 8'h80);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_released", out_reg, 8'h00);
    @(posedge clk);
    #1;
    check("mid_recover", out_reg, 8'h80);

    // Random traffic
    for (int n = 0; n < 1000; n++) begin
      ri = 1'($urandom_range(0, 1));
      rs = 3'($urandom_range(0, 7));
      exp_v = ri ? (8'h01 << rs) : 8'h00;
      apply(ri, rs, exp_v, "rand");
      check("rand_onehot_reg", 8'($countones(out_reg) <= 1), 8'h01);
      check("rand_onehot_comb", 8'($countones(out_comb) <= 1), 8'h01);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
